// File: rtl/board_bus_pkg.sv
// Shared definitions for the board query master and its bus port.
//   - Internal-bus address map of the Monte-Carlo responder
//   - Board geometry (16 cells of CELL_W bits)
//   - Top-level sequencer state encoding and one-access port state encoding
package board_bus_pkg;

    localparam int GRID_BASE   = 0;    // cell i lives at GRID_BASE + i
    localparam int SEED_ADDR   = 16;   // seed register; writing 0 halts the engines
    localparam int STAT_BASE   = 17;   // first statistics byte (direction 0, byte 0)
    localparam int STAT_STRIDE = 10;   // bytes per direction
    localparam int CELL_W      = 6;
    localparam int NUM_CELLS   = 16;
    localparam int NUM_DIRS    = 4;
    localparam int NUM_STAT    = NUM_DIRS * STAT_STRIDE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CELL,
        S_WR_SEED,
        S_RUN,
        S_RD_STAT,
        S_STOP,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_REQ,
        P_STROBE,
        P_WAIT
    } port_state_t;

endpackage

// File: rtl/bus_master_port.sv
// One-access internal-bus engine.
// A go pulse (accepted only when idle) latches addr/wdata/is_read and raises
// int_req. The first cycle int_gnt is seen high produces a one-cycle strobe,
// int_req drops the cycle after the strobe. Writes acknowledge right after the
// strobe; reads acknowledge when int_rd_data is captured RD_LAT cycles after
// the strobe cycle (RD_LAT values below 1 are treated as 1).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   go, is_read, addr, wdata access request from the sequencer
//   ack, rdata               one-cycle completion pulse, captured read byte
//   int_*                    internal-bus master signals
module bus_master_port
    import board_bus_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        is_read,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic [15:0] int_address,
    output logic [7:0]  int_wr_data,
    output logic        int_write,
    output logic        int_read,
    output logic        int_req,
    input  logic        int_gnt,
    input  logic [7:0]  int_rd_data
);

    localparam logic [7:0] LAT_INIT = (RD_LAT < 1) ? 8'd1 : 8'(RD_LAT);

    port_state_t pstate;
    logic        rd_mode;
    logic [7:0]  lat_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pstate      <= P_IDLE;
            rd_mode     <= 1'b0;
            lat_cnt     <= '0;
            ack         <= 1'b0;
            rdata       <= '0;
            int_address <= '0;
            int_wr_data <= '0;
            int_write   <= 1'b0;
            int_read    <= 1'b0;
            int_req     <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (pstate)
                P_IDLE: begin
                    if (go) begin
                        int_address <= addr;
                        int_wr_data <= wdata;
                        rd_mode     <= is_read;
                        int_req     <= 1'b1;
                        pstate      <= P_REQ;
                    end
                end
                P_REQ: begin
                    if (int_gnt) begin
                        int_write <= ~rd_mode;
                        int_read  <= rd_mode;
                        pstate    <= P_STROBE;
                    end
                end
                P_STROBE: begin
                    // Address/data stay put; only the request and strobe fall.
                    int_write <= 1'b0;
                    int_read  <= 1'b0;
                    int_req   <= 1'b0;
                    if (rd_mode) begin
                        lat_cnt <= LAT_INIT;
                        pstate  <= P_WAIT;
                    end else begin
                        ack    <= 1'b1;
                        pstate <= P_IDLE;
                    end
                end
                P_WAIT: begin
                    // lat_cnt==1 marks the edge closing the RD_LAT-th cycle
                    // after the strobe, where read data is valid.
                    if (lat_cnt == 8'd1) begin
                        rdata  <= int_rd_data;
                        ack    <= 1'b1;
                        pstate <= P_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                default: pstate <= P_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/board_query_master.sv
// Internal-bus initiator for the Monte-Carlo responder.
// On an accepted start it writes the 16 board cells and the seed, waits
// RUN_CYCLES clocks, reads the 40 statistic bytes, assembles per-direction
// max_move / total_move / total_trial words and reports the direction with
// the largest total_move (lowest index on ties).
// Build option: define MONTE_STOP_EN to add a final write of 0 to the seed
// address after the reads, halting the engines before done.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, board, seed        request and its operands (seed must be non-zero)
//   busy, done, err_seed      status; done/err_seed are one-cycle pulses
//   max_move, total_move,
//   total_trial, best_dir     results, flattened {d3,d2,d1,d0}, updated at done
//   int_*                     internal-bus master interface
module board_query_master #(
    parameter int RUN_CYCLES = 100000,
    parameter int RD_LAT     = 1,
    parameter int STAT_BASE  = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [95:0]  board,
    input  logic [7:0]   seed,
    output logic         busy,
    output logic         done,
    output logic         err_seed,
    output logic [63:0]  max_move,
    output logic [127:0] total_move,
    output logic [127:0] total_trial,
    output logic [1:0]   best_dir,
    output logic [15:0]  int_address,
    output logic [7:0]   int_wr_data,
    output logic         int_write,
    output logic         int_read,
    output logic         int_req,
    input  logic         int_gnt,
    input  logic [7:0]   int_rd_data
);

    import board_bus_pkg::state_t, board_bus_pkg::S_IDLE, board_bus_pkg::S_WR_CELL,
           board_bus_pkg::S_WR_SEED, board_bus_pkg::S_RUN, board_bus_pkg::S_RD_STAT,
           board_bus_pkg::S_STOP, board_bus_pkg::S_DONE, board_bus_pkg::GRID_BASE,
           board_bus_pkg::SEED_ADDR, board_bus_pkg::STAT_STRIDE, board_bus_pkg::CELL_W,
           board_bus_pkg::NUM_CELLS, board_bus_pkg::NUM_DIRS, board_bus_pkg::NUM_STAT;

    localparam logic [31:0] RUN_LAST  = (RUN_CYCLES > 0) ? 32'(RUN_CYCLES - 1) : 32'd0;
    localparam logic [5:0]  LAST_CELL = 6'(NUM_CELLS - 1);
    localparam logic [5:0]  LAST_STAT = 6'(NUM_STAT - 1);

    state_t      state;
    logic [5:0]  cnt_reg;       // byte/cell index, saturates at the last access
    logic [31:0] run_cnt_reg;
    logic        pending_reg;   // an access has been issued and not yet acked
    logic [95:0] board_reg;
    logic [7:0]  seed_reg;

    logic        go_reg;
    logic        is_read_reg;
    logic [15:0] addr_reg;
    logic [7:0]  wdata_reg;
    logic        ack;
    logic [7:0]  rdata;

    logic [7:0]        stat_bytes [NUM_STAT];
    logic [CELL_W-1:0] cells      [NUM_CELLS];
    logic [15:0]       mm_w       [NUM_DIRS];
    logic [31:0]       tm_w       [NUM_DIRS];
    logic [31:0]       tt_w       [NUM_DIRS];
    logic [1:0]        best_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
            assign cells[gi] = board_reg[gi*CELL_W +: CELL_W];
        end
        // Little-endian: bytes 0-1 max_move, 2-5 total_move, 6-9 total_trial.
        for (gi = 0; gi < NUM_DIRS; gi++) begin : g_dir
            localparam int B = gi * STAT_STRIDE;
            assign mm_w[gi] = {stat_bytes[B+1], stat_bytes[B]};
            assign tm_w[gi] = {stat_bytes[B+5], stat_bytes[B+4], stat_bytes[B+3], stat_bytes[B+2]};
            assign tt_w[gi] = {stat_bytes[B+9], stat_bytes[B+8], stat_bytes[B+7], stat_bytes[B+6]};
        end
    endgenerate

    // Strictly-greater scan in direction order keeps the lowest index on ties.
    always_comb begin
        best_next = 2'd0;
        for (int d = 1; d < NUM_DIRS; d++) begin
            if (tm_w[d] > tm_w[best_next]) begin
                best_next = 2'(d);
            end
        end
    end

    bus_master_port #(
        .RD_LAT(RD_LAT)
    ) u_port (
        .clk        (clk),
        .rst        (rst),
        .go         (go_reg),
        .is_read    (is_read_reg),
        .addr       (addr_reg),
        .wdata      (wdata_reg),
        .ack        (ack),
        .rdata      (rdata),
        .int_address(int_address),
        .int_wr_data(int_wr_data),
        .int_write  (int_write),
        .int_read   (int_read),
        .int_req    (int_req),
        .int_gnt    (int_gnt),
        .int_rd_data(int_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt_reg     <= '0;
            run_cnt_reg <= '0;
            pending_reg <= 1'b0;
            board_reg   <= '0;
            seed_reg    <= '0;
            go_reg      <= 1'b0;
            is_read_reg <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_seed    <= 1'b0;
            max_move    <= '0;
            total_move  <= '0;
            total_trial <= '0;
            best_dir    <= '0;
            for (int i = 0; i < NUM_STAT; i++) begin
                stat_bytes[i] <= '0;
            end
        end else begin
            go_reg   <= 1'b0;
            done     <= 1'b0;
            err_seed <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (seed == 8'h00) begin
                            err_seed <= 1'b1;
                        end else begin
                            board_reg   <= board;
                            seed_reg    <= seed;
                            busy        <= 1'b1;
                            cnt_reg     <= '0;
                            pending_reg <= 1'b0;
                            state       <= S_WR_CELL;
                        end
                    end
                end
                S_WR_CELL: begin
                    if (!pending_reg) begin
                        go_reg      <= 1'b1;
                        is_read_reg <= 1'b0;
                        addr_reg    <= 16'(GRID_BASE) + 16'(cnt_reg);
                        wdata_reg   <= 8'(cells[cnt_reg[3:0]]);
                        pending_reg <= 1'b1;
                    end else if (ack) begin
                        pending_reg <= 1'b0;
                        if (cnt_reg == LAST_CELL) begin
                            cnt_reg <= '0;
                            state   <= S_WR_SEED;
                        end else begin
                            cnt_reg <= cnt_reg + 6'd1;
                        end
                    end
                end
                S_WR_SEED: begin
                    if (!pending_reg) begin
                        go_reg      <= 1'b1;
                        is_read_reg <= 1'b0;
                        addr_reg    <= 16'(SEED_ADDR);
                        wdata_reg   <= seed_reg;
                        pending_reg <= 1'b1;
                    end else if (ack) begin
                        pending_reg <= 1'b0;
                        run_cnt_reg <= '0;
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (run_cnt_reg >= RUN_LAST) begin
                        cnt_reg <= '0;
                        state   <= S_RD_STAT;
                    end else begin
                        run_cnt_reg <= run_cnt_reg + 32'd1;
                    end
                end
                S_RD_STAT: begin
                    // Byte index 10*d+k is exactly the offset from STAT_BASE.
                    if (!pending_reg) begin
                        go_reg      <= 1'b1;
                        is_read_reg <= 1'b1;
                        addr_reg    <= 16'(STAT_BASE) + 16'(cnt_reg);
                        wdata_reg   <= '0;
                        pending_reg <= 1'b1;
                    end else if (ack) begin
                        pending_reg         <= 1'b0;
                        stat_bytes[cnt_reg] <= rdata;
                        if (cnt_reg == LAST_STAT) begin
`ifdef MONTE_STOP_EN
                            state <= S_STOP;
`else
                            state <= S_DONE;
`endif
                        end else begin
                            cnt_reg <= cnt_reg + 6'd1;
                        end
                    end
                end
`ifdef MONTE_STOP_EN
                S_STOP: begin
                    // Writing 0 to the seed register halts the engines.
                    if (!pending_reg) begin
                        go_reg      <= 1'b1;
                        is_read_reg <= 1'b0;
                        addr_reg    <= 16'(SEED_ADDR);
                        wdata_reg   <= 8'h00;
                        pending_reg <= 1'b1;
                    end else if (ack) begin
                        pending_reg <= 1'b0;
                        state       <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    for (int d = 0; d < NUM_DIRS; d++) begin
                        max_move[d*16 +: 16]    <= mm_w[d];
                        total_move[d*32 +: 32]  <= tm_w[d];
                        total_trial[d*32 +: 32] <= tt_w[d];
                    end
                    best_dir <= best_next;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_query_master.sv
// Self-checking bench for board_query_master: a responder model drives
// int_gnt / int_rd_data, and a reference model predicts the access sequence,
// status pulses and final results directly from the operation's rules.
module tb_board_query_master;

    localparam int N_ACC_BASE = 16 + 1 + 40;
`ifdef MONTE_STOP_EN
    localparam int N_ACC = N_ACC_BASE + 1;
`else
    localparam int N_ACC = N_ACC_BASE;
`endif

    typedef struct packed {
        logic        rd;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [95:0]  board;
    logic [7:0]   seed;
    logic         busy, done, err_seed;
    logic [63:0]  max_move;
    logic [127:0] total_move, total_trial;
    logic [1:0]   best_dir;
    logic [15:0]  int_address;
    logic [7:0]   int_wr_data;
    logic         int_write, int_read, int_req;
    logic         int_gnt = 1'b0;
    logic [7:0]   int_rd_data = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    board_query_master #(
        .RUN_CYCLES(10),
        .RD_LAT    (1),
        .STAT_BASE (17)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .board      (board),
        .seed       (seed),
        .busy       (busy),
        .done       (done),
        .err_seed   (err_seed),
        .max_move   (max_move),
        .total_move (total_move),
        .total_trial(total_trial),
        .best_dir   (best_dir),
        .int_address(int_address),
        .int_wr_data(int_wr_data),
        .int_write  (int_write),
        .int_read   (int_read),
        .int_req    (int_req),
        .int_gnt    (int_gnt),
        .int_rd_data(int_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [7:0]   mem [0:63];          // responder memory (stat bytes)
    acc_t         exp_q[$];            // accesses still expected
    logic [24:0]  log_q[$];            // accesses observed in this run
    logic [321:0] exp_res = '0;
    bit           busy_m = 0, prev_strobe = 0, prev_req = 0, start_s = 0, rd_pend = 0;
    logic [7:0]   seed_s = '0;
    logic [95:0]  board_s = '0;
    logic [15:0]  rd_addr = '0;
    int           gnt_delay = -1;      // -1: grant tied high; N: grant after N cycles of request
    int           gnt_age = 0;
    int           done_cnt = 0, err_cnt = 0;

    function automatic logic [321:0] calc_results();
        logic [15:0] mm [4];
        logic [31:0] tm [4];
        logic [31:0] tt [4];
        int          best;
        for (int d = 0; d < 4; d++) begin
            int b = 17 + 10 * d;
            mm[d] = {mem[b+1], mem[b]};
            tm[d] = {mem[b+5], mem[b+4], mem[b+3], mem[b+2]};
            tt[d] = {mem[b+9], mem[b+8], mem[b+7], mem[b+6]};
        end
        best = 0;
        for (int d = 1; d < 4; d++) if (tm[d] > tm[best]) best = d;
        return {mm[3], mm[2], mm[1], mm[0], tm[3], tm[2], tm[1], tm[0],
                tt[3], tt[2], tt[1], tt[0], 2'(best)};
    endfunction

    // Compare process and responder: outputs registered at a posedge are
    // checked at the following negedge; inputs seen here are the ones the
    // DUT samples at the next posedge.
    always @(negedge clk) begin
        acc_t a;
        logic exp_err;
        bit   rd_now;
        if (rst) begin
            busy_m = 0; exp_q.delete(); prev_strobe = 0; prev_req = 0;
            start_s = 0; rd_pend = 0; gnt_age = 0; int_gnt = 1'b0; exp_res = '0;
        end else begin
            exp_err = 1'b0;
            rd_now  = 1'b0;
            if (start_s && !busy_m) begin
                if (seed_s == 8'h00) begin
                    exp_err = 1'b1;
                end else begin
                    busy_m = 1;
                    exp_q.delete();
                    for (int i = 0; i < 16; i++)
                        exp_q.push_back({1'b0, 16'(i), 2'b00, board_s[6*i +: 6]});
                    exp_q.push_back({1'b0, 16'd16, seed_s});
                    for (int k = 0; k < 40; k++)
                        exp_q.push_back({1'b1, 16'(17 + k), 8'h00});
`ifdef MONTE_STOP_EN
                    exp_q.push_back({1'b0, 16'd16, 8'h00});
`endif
                end
            end
            if (err_seed) err_cnt++;
            chk("err_seed", err_seed, exp_err);

            if (int_write || int_read) begin
                chk("strobe_legal", {int_req, int_gnt, prev_strobe, busy_m, int_write & int_read},
                    5'b11010);
                chk("access_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    a = exp_q.pop_front();
                    chk("access", {int_read, int_address, int_read ? 8'h00 : int_wr_data}, a);
                end
                log_q.push_back({int_read, int_address, int_read ? 8'h00 : int_wr_data});
                $display("[%0t] %s addr=%04h data=%02h", $time, int_read ? "RD" : "WR",
                         int_address, int_read ? 8'h00 : int_wr_data);
                rd_now = int_read;
            end else begin
                if (prev_strobe) chk("req_drop", int_req, 0);
                else if (prev_req) chk("req_hold", int_req, 1);
                if (int_req && exp_q.size() > 0)
                    chk("addr_hold", {int_address, exp_q[0].rd ? 8'h00 : int_wr_data},
                        {exp_q[0].addr, exp_q[0].data});
            end

            if (done) begin
                done_cnt++;
                chk("done_legal", {busy_m, exp_q.size() == 0}, 2'b11);
                exp_res = calc_results();
                busy_m = 0;
            end
            chk("busy", busy, busy_m);
            chk("results", {max_move, total_move, total_trial, best_dir}, exp_res);

            // Responder: read data is valid only during the cycle after the strobe.
            int_rd_data = rd_pend ? mem[rd_addr[5:0]] : 8'($urandom);
            rd_pend = rd_now;
            rd_addr = int_address;
            if (gnt_delay < 0) begin
                int_gnt = 1'b1;
            end else if (int_req) begin
                gnt_age++;
                int_gnt = (gnt_age > gnt_delay);
            end else begin
                gnt_age = 0;
                int_gnt = 1'b0;
            end

            prev_strobe = int_write | int_read;
            prev_req    = int_req;
            start_s     = start;
            seed_s      = seed;
            board_s     = board;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start(input logic [95:0] b, input logic [7:0] s);
        @(posedge clk); #1;
        board = b; seed = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_query(input logic [95:0] b, input logic [7:0] s, input bit extra_start);
        int d0;
        int guard;
        d0 = done_cnt;
        guard = 0;
        log_q.delete();
        do_start(b, s);
        if (extra_start) begin
            repeat (5) @(posedge clk);
            #1 board = ~b; seed = 8'h77; start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        while (done_cnt == d0 && guard < 20000) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("query_done", done_cnt != d0, 1);
    endtask

    task automatic check_ramp_results(input string tag);
        chk({tag, "_tm0"}, total_move[31:0], 32'h16151413);
        chk({tag, "_mm3"}, max_move[63:48], 16'h302F);
        chk({tag, "_best"}, best_dir, 2'd3);
        chk({tag, "_len"}, log_q.size(), N_ACC);
    endtask

    logic [95:0] ramp;
    int e0, guard5;

    initial begin
        rst = 1'b1; start = 1'b0; board = '0; seed = '0;
        for (int a = 0; a < 64; a++) mem[a] = 8'(a);
        for (int i = 0; i < 16; i++) ramp[6*i +: 6] = 6'(i);
        #2;
        chk("reset_async", {busy, done, err_seed, int_req, int_write, int_read, int_address,
                            int_wr_data, max_move, total_move, total_trial, best_dir}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        chk("reset_state", {busy, done, err_seed, int_req, int_write, int_read, int_address,
                            int_wr_data, max_move, total_move, total_trial, best_dir}, 0);

        // Grant tied high, ramp board, byte = address responder.
        gnt_delay = -1;
        run_query(ramp, 8'h5A, 0);
        check_ramp_results("t1");
        if (log_q.size() >= 17) begin
            for (int i = 0; i < 16; i++)
                chk("t1_cell_write", log_q[i], {1'b0, 16'(i), 8'(i)});
            chk("t1_seed_write", log_q[16], {1'b0, 16'd16, 8'h5A});
        end

        // Grant withheld for 7 cycles on every access.
        gnt_delay = 7;
        run_query(ramp, 8'h5A, 0);
        check_ramp_results("t3");

        // Zero seed is rejected with no bus traffic.
        gnt_delay = -1;
        e0 = err_cnt;
        log_q.delete();
        do_start(ramp, 8'h00);
        repeat (10) @(negedge clk);
        #1;
        chk("t4_err_pulse", err_cnt - e0, 1);
        chk("t4_no_access", log_q.size(), 0);
        chk("t4_busy", busy, 0);

        // Reset in the middle of the statistics reads.
        gnt_delay = 0;
        log_q.delete();
        do_start(~ramp, 8'h33);
        guard5 = 0;
        while (log_q.size() < 38 && guard5 < 5000) begin
            @(negedge clk); #1;
            guard5++;
        end
        chk("t5_reached_byte20", log_q.size() >= 38, 1);
        rst = 1'b1;
        #1;
        chk("t5_req_drop", int_req, 0);
        chk("t5_outputs_zero", {busy, done, err_seed, int_write, int_read, int_address,
                                int_wr_data, max_move, total_move, total_trial, best_dir}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        gnt_delay = -1;
        run_query(ramp, 8'h5A, 0);
        check_ramp_results("t5");

        // Equal total_move on every direction: lowest index wins.
        for (int d = 0; d < 4; d++)
            for (int k = 2; k < 6; k++) mem[17 + 10*d + k] = 8'hA5;
        run_query(ramp, 8'h11, 0);
        chk("t6_best_tie", best_dir, 2'd0);
        if (log_q.size() > 0) begin
`ifdef MONTE_STOP_EN
            chk("t6_last_access", log_q[log_q.size()-1], {1'b0, 16'd16, 8'h00});
`else
            chk("t6_last_access", log_q[log_q.size()-1], {1'b1, 16'd56, 8'h00});
`endif
        end

        // Randomized runs with varying grant latency and ignored restarts.
        for (int r = 0; r < 8; r++) begin
            for (int a = 17; a < 57; a++) mem[a] = 8'($urandom);
            if (r == 3) for (int k = 2; k < 6; k++) mem[17 + 10 + k] = mem[17 + 30 + k];
            gnt_delay = int'($urandom_range(0, 5)) - 1;
            run_query({$urandom, $urandom, $urandom}, 8'($urandom_range(1, 255)), r[0]);
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
